// File: rtl/cic_ctrl_pkg.sv
// Shared types, constants and helpers for the CIC decimation controller.
// CIC_CTRL_FRAME_HDR_EN adds a one-byte frame-counter header to every word.
package cic_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam int OUT_W_DEF = 24;
  localparam int NB        = OUT_W_DEF / 8;

`ifdef CIC_CTRL_FRAME_HDR_EN
  localparam int HDR_BYTES = 1;
`else
  localparam int HDR_BYTES = 0;
`endif

  function automatic int nb_of(input int out_w);
    return out_w / 8;
  endfunction

  // A ratio of 0 behaves exactly like a ratio of 1.
  function automatic logic [31:0] norm_ratio(input logic [31:0] r);
    if (r == 32'd0) begin
      return 32'd1;
    end else begin
      return r;
    end
  endfunction

endpackage

// File: rtl/cic_decim_ctrl_if.sv
// Comb-result input and serialized byte-stream output of the CIC controller.
interface cic_decim_ctrl_if #(
  parameter int OUT_W = cic_ctrl_pkg::NB * 8
);
  logic [OUT_W-1:0] cic_data;
  logic             cic_valid;
  logic [7:0]       out_byte;
  logic             out_valid;
  logic             out_ready;

  modport master (
    input  cic_data, cic_valid, out_ready,
    output out_byte, out_valid
  );

  modport slave (
    output cic_data, cic_valid, out_ready,
    input  out_byte, out_valid
  );
endinterface

// File: rtl/cic_byte_serializer.sv
// Breaks each comb word into MSB-first bytes on a valid/ready stream and flags dropped words.
// CIC_CTRL_FRAME_HDR_EN prepends an 8-bit frame counter byte to each word.
module cic_byte_serializer
  import cic_ctrl_pkg::*;
#(
  parameter int OUT_W = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             accept_en,
  input  logic [OUT_W-1:0] cic_data,
  input  logic             cic_valid,
  input  logic             out_ready,
  output logic [7:0]       out_byte,
  output logic             out_valid,
  output logic             overrun,
  output logic             empty
);

  localparam int WB    = nb_of(OUT_W) + HDR_BYTES;
  localparam int IDX_W = $clog2(WB + 1);

  logic [OUT_W-1:0] sh_r;
  logic [IDX_W-1:0] left_r;
  logic [7:0]       byte_r;
  logic             valid_r;
  logic             ovr_r;
`ifdef CIC_CTRL_FRAME_HDR_EN
  logic [7:0]       frame_r;
`endif

  logic hs_s;
  logic final_s;
  logic load_s;
  logic drop_s;

  // Handshake decode: a new word may enter only as the last byte leaves.
  always_comb begin
    hs_s    = valid_r & out_ready;
    final_s = hs_s & (left_r == {IDX_W{1'b0}});
    load_s  = accept_en & cic_valid & (~valid_r | final_s);
    drop_s  = accept_en & cic_valid & valid_r & ~final_s;
  end

  // Shift register, remaining-byte count, output byte and sticky overrun.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh_r    <= {OUT_W{1'b0}};
      left_r  <= {IDX_W{1'b0}};
      byte_r  <= 8'h00;
      valid_r <= 1'b0;
      ovr_r   <= 1'b0;
`ifdef CIC_CTRL_FRAME_HDR_EN
      frame_r <= 8'h00;
`endif
    end else begin
      if (clear) begin
        ovr_r <= 1'b0;
      end else if (drop_s) begin
        ovr_r <= 1'b1;
      end

`ifdef CIC_CTRL_FRAME_HDR_EN
      if (clear) begin
        frame_r <= 8'h00;
      end else if (load_s) begin
        frame_r <= frame_r + 8'd1;
      end
`endif

      if (load_s) begin
        valid_r <= 1'b1;
        left_r  <= IDX_W'(WB - 1);
`ifdef CIC_CTRL_FRAME_HDR_EN
        byte_r  <= frame_r;
        sh_r    <= cic_data;
`else
        byte_r  <= cic_data[OUT_W-1 -: 8];
        sh_r    <= cic_data << 8;
`endif
      end else if (hs_s) begin
        if (final_s) begin
          valid_r <= 1'b0;
        end else begin
          byte_r <= sh_r[OUT_W-1 -: 8];
          sh_r   <= sh_r << 8;
          left_r <= left_r - IDX_W'(1);
        end
      end
    end
  end

  assign out_byte  = byte_r;
  assign out_valid = valid_r;
  assign overrun   = ovr_r;
  assign empty     = ~valid_r & ~load_s;

endmodule

// File: rtl/cic_decim_ctrl.sv
// CIC decimation sequencer: prescaled integrator strobe, comb strobe every R samples, byte serializer.
// CIC_CTRL_FRAME_HDR_EN enables the per-word frame header in the serializer.
module cic_decim_ctrl
  import cic_ctrl_pkg::*;
#(
  parameter int CNT_W = 16,
  parameter int R_W   = 8,
  parameter int OUT_W = NB * 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_we,
  input  logic [CNT_W-1:0] cfg_prescale,
  input  logic [R_W-1:0]   cfg_ratio,
  input  logic             start,
  input  logic             stop,
  output logic             integ_en,
  output logic             comb_en,
  output logic             busy,
  output logic             overrun,
  cic_decim_ctrl_if.master bus
);

  state_t           state_r;
  logic [CNT_W-1:0] prescale_r;
  logic [R_W-1:0]   ratio_r;
  logic [CNT_W-1:0] pcnt_r;
  logic [R_W-1:0]   dcnt_r;
  logic             integ_r;
  logic             comb_r;
  logic             busy_r;

  logic clear_s;
  logic accept_s;
  logic ser_empty_s;

  assign clear_s  = (state_r == IDLE) & start;
  assign accept_s = (state_r != IDLE);

  // Sequencer FSM with config latch, prescaler and decimation counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= IDLE;
      prescale_r <= {CNT_W{1'b0}};
      ratio_r    <= R_W'(1);
      pcnt_r     <= {CNT_W{1'b0}};
      dcnt_r     <= {R_W{1'b0}};
      integ_r    <= 1'b0;
      comb_r     <= 1'b0;
      busy_r     <= 1'b0;
    end else begin
      integ_r <= 1'b0;
      comb_r  <= 1'b0;
      case (state_r)
        IDLE: begin
          if (cfg_we) begin
            prescale_r <= cfg_prescale;
            ratio_r    <= R_W'(norm_ratio(32'(cfg_ratio)));
          end
          if (start) begin
            state_r <= RUN;
            busy_r  <= 1'b1;
            pcnt_r  <= {CNT_W{1'b0}};
            dcnt_r  <= {R_W{1'b0}};
          end
        end
        RUN: begin
          // A stop abandons the partial period; no strobe leaks into DRAIN.
          if (stop) begin
            state_r <= DRAIN;
          end else if (pcnt_r == prescale_r) begin
            pcnt_r  <= {CNT_W{1'b0}};
            integ_r <= 1'b1;
            if (dcnt_r == ratio_r - R_W'(1)) begin
              dcnt_r <= {R_W{1'b0}};
              comb_r <= 1'b1;
            end else begin
              dcnt_r <= dcnt_r + R_W'(1);
            end
          end else begin
            pcnt_r <= pcnt_r + CNT_W'(1);
          end
        end
        DRAIN: begin
          if (ser_empty_s) begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
          end
        end
        default: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  cic_byte_serializer #(
    .OUT_W(OUT_W)
  ) u_ser (
    .clk       (clk),
    .rst       (rst),
    .clear     (clear_s),
    .accept_en (accept_s),
    .cic_data  (bus.cic_data),
    .cic_valid (bus.cic_valid),
    .out_ready (bus.out_ready),
    .out_byte  (bus.out_byte),
    .out_valid (bus.out_valid),
    .overrun   (overrun),
    .empty     (ser_empty_s)
  );

  assign integ_en = integ_r;
  assign comb_en  = comb_r;
  assign busy     = busy_r;

endmodule

// File: tb/tb_cic_decim_ctrl.sv
// Scoreboard bench for cic_decim_ctrl: strobe timing, byte stream, backpressure, overrun, drain.
module tb_cic_decim_ctrl;

  localparam int WB = 3 + cic_ctrl_pkg::HDR_BYTES;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cfg_we = 1'b0;
  logic [15:0] cfg_prescale = 16'd0;
  logic [7:0]  cfg_ratio = 8'd0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        integ_en, comb_en, busy, overrun;

  int total = 0;
  int bad = 0;
  logic [7:0] exp_q[$];
  logic [7:0] mon_exp;
  int frm_m = 0;

  cic_decim_ctrl_if #(.OUT_W(24)) bus ();

  cic_decim_ctrl #(.CNT_W(16), .R_W(8), .OUT_W(24)) dut (
    .clk          (clk),
    .rst          (rst),
    .cfg_we       (cfg_we),
    .cfg_prescale (cfg_prescale),
    .cfg_ratio    (cfg_ratio),
    .start        (start),
    .stop         (stop),
    .integ_en     (integ_en),
    .comb_en      (comb_en),
    .busy         (busy),
    .overrun      (overrun),
    .bus          (bus)
  );

  always #5 clk = ~clk;

  // Stream monitor: a handshake seen at the negedge completes on the next posedge.
  always @(negedge clk) begin
    if (!rst && bus.out_valid && bus.out_ready) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL stream_extra: got byte %02h, expected no byte", bus.out_byte);
      end else begin
        mon_exp = exp_q.pop_front();
        if (bus.out_byte !== mon_exp) begin
          bad++;
          $display("FAIL stream_byte: got %02h want %02h", bus.out_byte, mon_exp);
        end
      end
    end
  end

  initial begin
    #800000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push_word(input logic [23:0] w);
`ifdef CIC_CTRL_FRAME_HDR_EN
    exp_q.push_back(8'(frm_m));
    frm_m = (frm_m + 1) % 256;
`endif
    exp_q.push_back(w[23:16]);
    exp_q.push_back(w[15:8]);
    exp_q.push_back(w[7:0]);
  endtask

  task automatic send_word(input logic [23:0] w);
    bus.cic_data  = w;
    bus.cic_valid = 1'b1;
    cyc(1);
    bus.cic_valid = 1'b0;
  endtask

  task automatic start_run(input logic we, input logic [15:0] ps, input logic [7:0] r);
    cfg_we       = we;
    cfg_prescale = ps;
    cfg_ratio    = r;
    start        = 1'b1;
    cyc(1);
    start  = 1'b0;
    cfg_we = 1'b0;
    frm_m  = 0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cyc(2);
    total++;
    if ({integ_en, comb_en, bus.out_valid, busy, overrun} !== 5'b00000) begin
      bad++;
      $display("FAIL reset_flags: got integ,comb,valid,busy,ovr=%b want 00000",
               {integ_en, comb_en, bus.out_valid, busy, overrun});
    end
    total++;
    if (bus.out_byte !== 8'h00) begin
      bad++;
      $display("FAIL reset_out_byte: got %02h want 00", bus.out_byte);
    end
    rst = 1'b0;
    cyc(1);
  endtask

  task automatic test_strobes();
    start_run(1'b1, 16'd3, 8'd4);
    for (int k = 1; k <= 47; k++) begin
      if (k == 10) begin
        cfg_we       = 1'b1;
        cfg_prescale = 16'd7;
        cfg_ratio    = 8'd2;
      end
      cyc(1);
      cfg_we = 1'b0;
      total++;
      if (integ_en !== (k % 4 == 0) || comb_en !== (k % 16 == 0) || busy !== 1'b1) begin
        bad++;
        $display("FAIL strobe_k%0d: got integ=%b comb=%b busy=%b want integ=%b comb=%b busy=1",
                 k, integ_en, comb_en, busy, (k % 4 == 0), (k % 16 == 0));
      end
    end
    stop = 1'b1;
    cyc(1);
    stop = 1'b0;
    total++;
    if (integ_en !== 1'b0 || comb_en !== 1'b0 || busy !== 1'b1) begin
      bad++;
      $display("FAIL stop_edge: got integ=%b comb=%b busy=%b want 0 0 1", integ_en, comb_en, busy);
    end
    cyc(1);
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL stop_idle: got busy=%b want 0", busy);
    end
    for (int k = 0; k < 20; k++) begin
      cyc(1);
      total++;
      if (integ_en !== 1'b0 || comb_en !== 1'b0) begin
        bad++;
        $display("FAIL idle_strobe_%0d: got integ=%b comb=%b want 0 0", k, integ_en, comb_en);
      end
    end
  endtask

  task automatic test_serial();
    logic [7:0] first;
    start_run(1'b0, 16'd0, 8'd0);
    bus.out_ready = 1'b1;
    push_word(24'hA1B2C3);
    first = exp_q[0];
    send_word(24'hA1B2C3);
    total++;
    if (bus.out_valid !== 1'b1 || bus.out_byte !== first) begin
      bad++;
      $display("FAIL serial_first: got valid=%b byte=%02h want 1 %02h", bus.out_valid, bus.out_byte, first);
    end
    cyc(WB);
    total++;
    if (bus.out_valid !== 1'b0 || exp_q.size() != 0) begin
      bad++;
      $display("FAIL serial_end: got valid=%b pending=%0d want 0 0", bus.out_valid, exp_q.size());
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] hold;
    bus.out_ready = 1'b0;
    push_word(24'hA1B2C3);
    hold = exp_q[0];
    send_word(24'hA1B2C3);
    for (int i = 0; i < 5; i++) begin
      total++;
      if (bus.out_valid !== 1'b1 || bus.out_byte !== hold) begin
        bad++;
        $display("FAIL bp_hold_%0d: got valid=%b byte=%02h want 1 %02h", i, bus.out_valid, bus.out_byte, hold);
      end
      cyc(1);
    end
    bus.out_ready = 1'b1;
    cyc(WB);
    total++;
    if (bus.out_valid !== 1'b0 || exp_q.size() != 0) begin
      bad++;
      $display("FAIL bp_end: got valid=%b pending=%0d want 0 0", bus.out_valid, exp_q.size());
    end
  endtask

  task automatic test_overrun();
    bus.out_ready = 1'b1;
    push_word(24'h112233);
    send_word(24'h112233);
    cyc(1);
    send_word(24'h445566);
    total++;
    if (overrun !== 1'b1) begin
      bad++;
      $display("FAIL overrun_set: got %b want 1", overrun);
    end
    cyc(WB + 1);
    total++;
    if (bus.out_valid !== 1'b0 || exp_q.size() != 0) begin
      bad++;
      $display("FAIL overrun_stream: got valid=%b pending=%0d want 0 0", bus.out_valid, exp_q.size());
    end
    stop = 1'b1;
    cyc(1);
    stop = 1'b0;
    cyc(1);
    total++;
    if (busy !== 1'b0 || overrun !== 1'b1) begin
      bad++;
      $display("FAIL overrun_sticky: got busy=%b ovr=%b want 0 1", busy, overrun);
    end
    start_run(1'b0, 16'd0, 8'd0);
    total++;
    if (overrun !== 1'b0) begin
      bad++;
      $display("FAIL overrun_clear: got %b want 0", overrun);
    end
  endtask

  task automatic test_back_to_back();
    bus.out_ready = 1'b1;
    push_word(24'h010203);
    send_word(24'h010203);
    cyc(WB - 1);
    push_word(24'h0A0B0C);
    send_word(24'h0A0B0C);
    total++;
    if (bus.out_valid !== 1'b1 || overrun !== 1'b0) begin
      bad++;
      $display("FAIL b2b_cont: got valid=%b ovr=%b want 1 0", bus.out_valid, overrun);
    end
    cyc(WB);
    total++;
    if (bus.out_valid !== 1'b0 || exp_q.size() != 0) begin
      bad++;
      $display("FAIL b2b_end: got valid=%b pending=%0d want 0 0", bus.out_valid, exp_q.size());
    end
  endtask

  task automatic test_drain();
    bus.out_ready = 1'b0;
    push_word(24'hA1B2C3);
    send_word(24'hA1B2C3);
    stop = 1'b1;
    cyc(1);
    stop = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cyc(1);
      total++;
      if (busy !== 1'b1 || integ_en !== 1'b0 || comb_en !== 1'b0) begin
        bad++;
        $display("FAIL drain_hold_%0d: got busy=%b integ=%b comb=%b want 1 0 0", i, busy, integ_en, comb_en);
      end
    end
    bus.out_ready = 1'b1;
    cyc(WB);
    total++;
    if (busy !== 1'b1) begin
      bad++;
      $display("FAIL drain_last: got busy=%b want 1", busy);
    end
    cyc(1);
    total++;
    if (busy !== 1'b0 || exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain_done: got busy=%b pending=%0d want 0 0", busy, exp_q.size());
    end
    send_word(24'hDEADBE);
    cyc(1);
    total++;
    if (bus.out_valid !== 1'b0) begin
      bad++;
      $display("FAIL idle_valid_ignored: got valid=%b want 0", bus.out_valid);
    end
  endtask

  task automatic test_start_stop_same();
    start = 1'b1;
    stop  = 1'b1;
    cyc(1);
    start = 1'b0;
    stop  = 1'b0;
    cyc(3);
    total++;
    if (busy !== 1'b1) begin
      bad++;
      $display("FAIL start_wins: got busy=%b want 1", busy);
    end
    stop = 1'b1;
    cyc(1);
    stop = 1'b0;
    cyc(1);
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL start_wins_stop: got busy=%b want 0", busy);
    end
  endtask

`ifdef CIC_CTRL_FRAME_HDR_EN
  task automatic test_frame_hdr();
    start_run(1'b0, 16'd0, 8'd0);
    bus.out_ready = 1'b1;
    for (int w = 0; w < 257; w++) begin
      push_word(24'(w * 3 + 5));
      send_word(24'(w * 3 + 5));
      cyc(WB - 1);
    end
    cyc(2);
    total++;
    if (exp_q.size() != 0 || overrun !== 1'b0) begin
      bad++;
      $display("FAIL frame_hdr_end: got pending=%0d ovr=%b want 0 0", exp_q.size(), overrun);
    end
    stop = 1'b1;
    cyc(1);
    stop = 1'b0;
    cyc(1);
  endtask
`endif

  task automatic test_reset_mid();
    start_run(1'b0, 16'd0, 8'd0);
    bus.out_ready = 1'b0;
    send_word(24'h5A5A5A);
    rst = 1'b1;
    #1;
    total++;
    if (bus.out_valid !== 1'b0 || busy !== 1'b0 || bus.out_byte !== 8'h00) begin
      bad++;
      $display("FAIL reset_mid: got valid=%b busy=%b byte=%02h want 0 0 00", bus.out_valid, busy, bus.out_byte);
    end
    cyc(1);
    rst = 1'b0;
    bus.out_ready = 1'b1;
    cyc(3);
    total++;
    if (bus.out_valid !== 1'b0) begin
      bad++;
      $display("FAIL reset_mid_discard: got valid=%b want 0", bus.out_valid);
    end
  endtask

  initial begin
    bus.cic_data  = 24'h000000;
    bus.cic_valid = 1'b0;
    bus.out_ready = 1'b0;
    test_reset();
    test_strobes();
    test_serial();
    test_backpressure();
    test_overrun();
    test_back_to_back();
    test_drain();
    test_start_stop_same();
`ifdef CIC_CTRL_FRAME_HDR_EN
    test_frame_hdr();
`endif
    test_reset_mid();
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL final_queue: got pending=%0d want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cic_decim_ctrl.md
Name: cic_decim_ctrl

Overview:
Sequencer for the CIC decimation datapath behind the Tiny Tapeout wrapper. It generates the integrator-stage sample strobe from a programmable prescaler and the comb-stage strobe once every R samples. It serializes each wide comb result onto an 8-bit valid/ready byte stream for the output pins. Configuration is latched only while idle.

Parameters:
CNT_W, 16, prescaler width (input sample period = cfg_prescale+1 clocks)
R_W, 8, decimation-ratio width
OUT_W, 24, comb result width; must be a multiple of 8; NB = OUT_W/8 bytes per word

Ports:
clk  in  1  system clock, all logic rising-edge
rst  in  1  asynchronous, active-high reset
cfg_we  in  1  latch cfg_prescale/cfg_ratio (honoured in IDLE only)
cfg_prescale  in  CNT_W  prescaler terminal count
cfg_ratio  in  R_W  decimation ratio R; 0 and 1 both mean R=1
start  in  1  single-cycle request to begin decimation
stop  in  1  single-cycle request to end decimation
integ_en  out  1  one-cycle pulse: integrators accept a sample
comb_en  out  1  one-cycle pulse: combs compute one decimated output
cic_data  in  OUT_W  comb result
cic_valid  in  1  cic_data valid this cycle (from datapath)
out_byte  out  8  serialized byte, MSB byte first
out_valid  out  1  out_byte valid
out_ready  in  1  sink accepts out_byte
busy  out  1  high in RUN or DRAIN
overrun  out  1  sticky: a comb word was dropped

Behaviour:
- Reset: state IDLE; prescale reg 0, ratio reg 1; all counters 0; integ_en, comb_en, out_valid, busy, overrun = 0; out_byte = 0.
- FSM IDLE -> RUN on start; RUN -> DRAIN on stop; DRAIN -> IDLE when the serializer is empty (out_valid=0, no pending load). start is ignored outside IDLE. stop is ignored in IDLE. start+stop in the same cycle in IDLE: start wins, stop is dropped.
- cfg_we is honoured in IDLE only (including the same cycle as start; new values apply to that run). It is ignored in RUN/DRAIN.
- On entering RUN: prescale counter, decimation counter and overrun are cleared.
- Prescaler (RUN only): counts 0..cfg_prescale. integ_en pulses in the cycle the count equals cfg_prescale, then the count wraps to 0. prescale=0 gives integ_en every cycle. First integ_en comes prescale+1 cycles after the start edge.
- Decimation counter: increments on each integ_en and wraps at R-1. comb_en pulses in the same cycle as the integ_en that wraps it, i.e. every R-th integ_en.
- No strobes in IDLE or DRAIN. A stop mid-period abandons the partial count.
- Serializer: when cic_valid is high and the shift register is empty, or the final byte is handshaking this cycle, it loads the word. out_valid rises the next cycle with byte NB-1 (MSB). Each out_valid&out_ready advances one byte. out_byte and out_valid hold stable while out_valid&!out_ready.
- cic_valid while bytes are still pending (final byte not accepted this cycle): word dropped, overrun set. overrun is cleared only by rst or entering RUN.
- cic_valid in IDLE is ignored. cic_valid in DRAIN is accepted; the drain waits for it.
- rst mid-transfer: immediate return to reset values; partial word discarded.

Optional Feature:
CIC_CTRL_FRAME_HDR_EN. When defined, each word is preceded by a header byte holding an 8-bit frame counter (cleared on entering RUN, +1 per accepted word, wraps 255->0). Each word is NB+1 bytes, header first. When undefined, there is no header or counter and each word is exactly NB bytes.

Decomposition:
- Package cic_ctrl_pkg holds:
  - the state enum {IDLE, RUN, DRAIN}
  - localparam NB function of OUT_W
  - header byte-count constant
  - the R=0 -> 1 normalisation function
- Sub-module cic_byte_serializer: load/shift register, byte index, valid/ready, overrun detection, optional header. The top level keeps the FSM, prescaler and decimation counter.

Test Plan:
- prescale=3, R=4, start, out_ready=1 -> integ_en every 4 cycles, first at start+4; comb_en every 16 cycles, coincident with every 4th integ_en.
- cic_data=0xA1B2C3 valid one cycle, out_ready=1 -> bytes A1,B2,C3 on the next 3 cycles; out_valid low after.
- Same word, out_ready low 5 cycles after the first byte -> out_byte holds A1; no loss; sequence resumes A1,B2,C3.
- Second cic_valid while the B2 byte is pending -> overrun=1, second word absent from the stream. Next start clears overrun.
- cfg_we with prescale=7 during RUN -> ignored, period stays 4. stop with a word in flight -> busy held until C3 accepted, then IDLE; no strobes after stop.
- With CIC_CTRL_FRAME_HDR_EN: three words -> headers 00,01,02 precede each 3-byte word; 256 words -> header wraps to 00.
